tt_um_priority_decoder: RTL and testbench

TT_UM_PRIORITY_DECODER -- requirements
Module: tt_um_priority_decoder

---
 rtl/tt_um_priority_decoder_pkg.sv | 29 ++
 rtl/tt_um_priority_decoder_decode.sv | 27 ++
 rtl/tt_um_priority_decoder.sv | 117 +++++++++++
 tb/tb_tt_um_priority_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_priority_decoder_pkg.sv
// Purpose : shared constants for the priority-code frame decoder (code values,
//           state encoding, uio bit positions).
// Ports   : none (package).
package tt_um_priority_decoder_pkg;

   // Code value meaning "no bit set"; legal, but sets nothing.
   localparam logic [7:0] NONE_CODE = 8'hF0;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_e;

   // uio_in control bits
   localparam int UIO_CODE_VALID  = 0;
   localparam int UIO_FLUSH       = 1;
   localparam int UIO_OUT_READY   = 2;

   // uio_out status bits
   localparam int UIO_OUT_VALID   = 3;
   localparam int UIO_BUSY        = 4;
   localparam int UIO_ERR         = 5;
   localparam int UIO_BYTE_SEL    = 6;
   localparam int UIO_FRAME_EMPTY = 7;

   localparam logic [7:0] UIO_OE_VAL = 8'b1111_1000;

endpackage

// File: rtl/tt_um_priority_decoder_decode.sv
// Purpose : combinational code -> one-hot decode with legality check.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; consumer decides whether the code is accepted.
// Ports   : code_i    - priority code (0..15, NONE_CODE, anything else illegal)
//           onehot_o  - one-hot of code_i when 0..15, else zero
//           illegal_o - high when code_i is neither 0..15 nor NONE_CODE
module prio_code_decode
   import tt_um_priority_decoder_pkg::*;
#(
   parameter logic [7:0] NONE_CODE_P = NONE_CODE
) (
   input  logic [7:0]  code_i,
   output logic [15:0] onehot_o,
   output logic        illegal_o
);

   always_comb begin
      onehot_o  = '0;
      illegal_o = 1'b0;
      if (code_i < 8'd16) begin
         onehot_o[code_i[3:0]] = 1'b1;
      end else if (code_i != NONE_CODE_P) begin
         illegal_o = 1'b1;
      end
   end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Purpose : accumulate priority codes into a 16-bit vector, serialize each
//           flushed frame as two bytes (low first) with valid/ready handshake.
// Latency : first byte valid the cycle after the flush edge; 3-cycle min frame.
// Backpr. : out_ready low holds the current byte; flush ignored while sending.
// Ports   : clk, rst_n (async active-low), ena (no effect)
//           ui_in  - priority code;  uio_in - {.., out_ready, flush, code_valid}
//           uo_out - readout byte;   uio_out - {frame_empty, byte_sel, err, busy,
//           out_valid, 3'b0};        uio_oe - constant 8'b1111_1000
module tt_um_priority_decoder
   import tt_um_priority_decoder_pkg::*;
#(
   parameter logic [7:0] NONE_CODE = tt_um_priority_decoder_pkg::NONE_CODE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_e      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] shadow_q, shadow_d;
   logic        err_q, err_d;

   logic [15:0] onehot;
   logic        illegal;
   logic        code_valid, flush, out_ready;
   logic [15:0] hit;
   logic        bad;

   wire unused_ok = &{1'b0, ena, uio_in[7:3]};

   assign code_valid = uio_in[UIO_CODE_VALID];
   assign flush      = uio_in[UIO_FLUSH];
   assign out_ready  = uio_in[UIO_OUT_READY];

   prio_code_decode #(
      .NONE_CODE_P (NONE_CODE)
   ) u_decode (
      .code_i    (ui_in),
      .onehot_o  (onehot),
      .illegal_o (illegal)
   );

   assign hit = code_valid ? onehot : 16'h0000;
   assign bad = code_valid & illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= COLLECT;
         acc_q    <= '0;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
      end
   end

   // Codes accumulate in every state; only a COLLECT flush snapshots/clears.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q | hit;
      shadow_d = shadow_q;
      err_d    = err_q | bad;
      case (state_q)
         COLLECT: begin
            if (flush) begin
               // Same-edge code lands in the flushed frame, not in acc.
               shadow_d = acc_q | hit;
               acc_d    = '0;
               err_d    = bad;
               state_d  = SEND_LO;
            end
         end
         SEND_LO: begin
            if (out_ready) state_d = SEND_HI;
         end
         SEND_HI: begin
            if (out_ready) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   // Outputs decode only registered state, so they are stable under stall.
   always_comb begin
      uo_out  = 8'h00;
      uio_out = 8'h00;
      case (state_q)
         SEND_LO: begin
            uo_out                   = shadow_q[7:0];
            uio_out[UIO_OUT_VALID]   = 1'b1;
            uio_out[UIO_BUSY]        = 1'b1;
            uio_out[UIO_FRAME_EMPTY] = (shadow_q == 16'h0000);
         end
         SEND_HI: begin
            uo_out                   = shadow_q[15:8];
            uio_out[UIO_OUT_VALID]   = 1'b1;
            uio_out[UIO_BUSY]        = 1'b1;
            uio_out[UIO_BYTE_SEL]    = 1'b1;
            uio_out[UIO_FRAME_EMPTY] = (shadow_q == 16'h0000);
         end
         default: ;
      endcase
      uio_out[UIO_ERR] = err_q;
   end

   assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
module tb_tt_um_priority_decoder;

   localparam logic [7:0] V = 8'h01;  // code_valid
   localparam logic [7:0] F = 8'h02;  // flush
   localparam logic [7:0] R = 8'h04;  // out_ready

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total = 0;
   int bad   = 0;
   bit model_on = 0;

   tt_um_priority_decoder #(.NONE_CODE(8'hF0)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Frame bytes waiting to be read form a queue; status follows its size.
   logic [15:0] m_acc;
   logic        m_err;
   logic [15:0] m_shadow;
   logic [7:0]  m_q[$];
   logic [15:0] m_hit;
   logic        m_bad;
   logic        m_sending;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc    = 16'h0;
         m_err    = 1'b0;
         m_shadow = 16'h0;
         m_q.delete();
      end else begin
         m_hit = 16'h0;
         m_bad = 1'b0;
         if (uio_in[0]) begin
            if (ui_in < 8'd16) m_hit = 16'd1 << ui_in[3:0];
            else if (ui_in != 8'hF0) m_bad = 1'b1;
         end
         m_sending = (m_q.size() != 0);
         if (m_sending && uio_in[2]) void'(m_q.pop_front());
         if (!m_sending && uio_in[1]) begin
            m_shadow = m_acc | m_hit;
            m_q.push_back(m_shadow[7:0]);
            m_q.push_back(m_shadow[15:8]);
            m_acc = 16'h0;
            m_err = m_bad;
         end else begin
            m_acc = m_acc | m_hit;
            m_err = m_err | m_bad;
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0] e_uo;
      logic [7:0] e_uio;
      logic       busy;
      if (model_on) begin
         busy  = (m_q.size() != 0);
         e_uo  = busy ? m_q[0] : 8'h00;
         e_uio = {busy && (m_shadow == 16'h0), busy && (m_q.size() == 1),
                  m_err, busy, busy, 3'b000};
         chk("model_uo_out", uo_out, e_uo);
         chk("model_uio_out", uio_out, e_uio);
         chk("model_uio_oe", uio_oe, 8'hF8);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [7:0] code, input logic [7:0] ctl);
      ui_in  = code;
      uio_in = ctl;
      @(posedge clk);
      #2;
   endtask

   task automatic expect2(input string name, input logic [7:0] uo, input logic [7:0] uio);
      chk({name, "_uo"}, uo_out, uo);
      chk({name, "_uio"}, uio_out, uio);
   endtask

   initial begin
      ena    = 1'b1;
      rst_n  = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) @(posedge clk);
      #2;
      expect2("reset", 8'h00, 8'h00);
      chk("reset_oe", uio_oe, 8'hF8);
      rst_n    = 1'b1;
      model_on = 1'b1;

      // codes 3,15,0 then flush
      step(8'd3, V); step(8'd15, V); step(8'd0, V);
      step(8'h00, F);
      expect2("s1_lo", 8'h09, 8'h18);
      step(8'h00, R);
      expect2("s1_hi", 8'h80, 8'h58);
      step(8'h00, R);
      expect2("s1_idle", 8'h00, 8'h00);

      // NONE_CODE then flush
      step(8'hF0, V);
      expect2("s2_none", 8'h00, 8'h00);
      step(8'h00, F);
      expect2("s2_lo", 8'h00, 8'h98);
      step(8'h00, R);
      expect2("s2_hi", 8'h00, 8'hD8);
      step(8'h00, R);

      // illegal code then flush
      step(8'h20, V);
      expect2("s3_err", 8'h00, 8'h20);
      step(8'h00, F);
      expect2("s3_lo", 8'h00, 8'h98);
      step(8'h00, R);
      expect2("s3_hi", 8'h00, 8'hD8);
      step(8'h00, R);

      // code 12 with flush on same edge; acc must be empty afterwards
      step(8'd12, V | F);
      expect2("s4_lo", 8'h00, 8'h18);
      step(8'h00, R);
      expect2("s4_hi", 8'h10, 8'h58);
      step(8'h00, R);
      step(8'h00, F);
      expect2("s4_acc0", 8'h00, 8'h98);
      step(8'h00, R); step(8'h00, R);

      // stall in SEND_LO, code 1 and flush arrive meanwhile
      step(8'd4, V);
      step(8'h00, F);
      for (int i = 0; i < 5; i++) begin
         if (i == 1)      step(8'd1, V);
         else if (i == 2) step(8'h00, F);
         else             step(8'h00, 8'h00);
         expect2("s5_stall", 8'h10, 8'h18);
      end
      step(8'h00, R);
      expect2("s5_hi", 8'h00, 8'h58);
      step(8'h00, R);
      step(8'h00, F);
      expect2("s5_next_lo", 8'h02, 8'h18);
      step(8'h00, R);
      expect2("s5_next_hi", 8'h00, 8'h58);
      step(8'h00, R);

      // reset in SEND_HI
      step(8'd7, V);
      step(8'h00, F);
      step(8'h00, R);
      expect2("s6_hi", 8'h00, 8'h58);
      rst_n = 1'b0;
      #1;
      expect2("s6_rst", 8'h00, 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(8'h00, 8'h00);
      expect2("s6_after", 8'h00, 8'h00);
      step(8'h00, F);
      expect2("s6_lo", 8'h00, 8'h98);
      step(8'h00, R);
      expect2("s6_hi2", 8'h00, 8'hD8);
      step(8'h00, R);

      // randomized traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] code;
         logic [7:0] ctl;
         int pick;
         pick = $urandom_range(0, 9);
         if (pick < 6)       code = 8'($urandom_range(0, 15));
         else if (pick < 8)  code = 8'hF0;
         else                code = 8'($urandom_range(0, 255));
         ctl = 8'h00;
         ctl[0] = ($urandom_range(0, 1) == 1);
         ctl[1] = ($urandom_range(0, 6) == 0);
         ctl[2] = ($urandom_range(0, 9) < 6);
         ctl[7:3] = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         step(code, ctl);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
